mlp_frame_sequencer: RTL and testbench

- Sequences one inference of the combinational printed-MLP `top` datapath (packed feature input, class-index output).
- Takes ADC feature samples one at a time over a valid/ready stream and drives the ADC front-end channel select.
- Assembles the registered NUM_A×WIDTH_A input vector, waits a programmable settle time for the slow printed-logic MLP, then captures and presents the class with a result handshake.
- Sits between the sensor ADC mux and `top`.

---
 rtl/mlp_frame_sequencer.sv | 111 +++++++++++
 tb/tb_mlp_frame_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_frame_sequencer.sv
// Frame sequencer for the combinational printed-MLP datapath: gathers one ADC sample per
// channel, waits for the slow logic to settle, then holds the captured class until it is taken.
module mlp_frame_sequencer #(
    parameter int NUM_A         = 6,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_W       = 8,
    parameter int CH_W          = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
    output logic [CH_W-1:0]            ch_sel,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_class,
    output logic                       busy,
    output logic [FRAME_W-1:0]         frame_cnt
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   idx;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last_slot;
    logic              settle_done;
    logic              res_hs;

    assign s_ready     = (state == LOAD) && rst_n;
    assign accept      = s_valid && s_ready;
    assign last_slot   = (idx == CH_W'(NUM_A - 1));
    assign settle_done = (cnt == '0);
    assign res_hs      = res_valid && res_ready;
    assign ch_sel      = (state == LOAD) ? idx : '0;
    assign busy        = (state == SETTLE) || (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (accept && last_slot) state_nxt = SETTLE;
            SETTLE:  if (settle_done)         state_nxt = HOLD;
            HOLD:    if (res_hs)              state_nxt = LOAD;
            default:                          state_nxt = LOAD;
        endcase
    end

    // NOTE: the feature bank is an ordinary register set, so it is cleared by reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            mlp_inp   <= '0;
            res_class <= '0;
            res_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_A; i++) begin
                            if (idx == CH_W'(i)) mlp_inp[i*WIDTH_A +: WIDTH_A] <= s_data;
                        end
                        if (last_slot) begin
                            idx <= '0;
                            cnt <= CNT_W'(SETTLE_CYCLES - 1);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // Capture on the edge the countdown reaches zero; the bank stays frozen meanwhile.
                    if (!settle_done) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        res_class <= mlp_out;
                        res_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_hs) begin
                        res_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Scoreboard bench for mlp_frame_sequencer: directed frames push expected results, a monitor
// pops and compares on each rising res_valid; a second instance covers SETTLE_CYCLES=1 and wrap.
module tb_mlp_frame_sequencer;

    localparam int SETTLE = 4;

    logic        clk;
    logic        rst_n;
    logic        s_valid, s_ready;
    logic [3:0]  s_data;
    logic [2:0]  ch_sel;
    logic [23:0] mlp_inp;
    logic [1:0]  mlp_out;
    logic        res_valid, res_ready;
    logic [1:0]  res_class;
    logic        busy;
    logic [7:0]  frame_cnt;

    logic        s_valid_b, s_ready_b;
    logic [3:0]  s_data_b;
    logic [2:0]  ch_sel_b;
    logic [23:0] mlp_inp_b;
    logic [1:0]  mlp_out_b;
    logic        res_valid_b, res_ready_b;
    logic [1:0]  res_class_b;
    logic        busy_b;
    logic [7:0]  frame_cnt_b;

    typedef struct {
        logic [23:0] inp;
        logic [1:0]  cls;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_frames = 0;
    logic prev_rv = 1'b0;

    mlp_frame_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ch_sel(ch_sel), .mlp_inp(mlp_inp), .mlp_out(mlp_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_class(res_class), .busy(busy), .frame_cnt(frame_cnt)
    );

    mlp_frame_sequencer #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .ch_sel(ch_sel_b), .mlp_inp(mlp_inp_b), .mlp_out(mlp_out_b), .res_valid(res_valid_b),
        .res_ready(res_ready_b), .res_class(res_class_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every new result must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (res_valid && !prev_rv) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_class", 32'(res_class), 32'(e.cls));
                check("result_inp", 32'(mlp_inp), 32'(e.inp));
                check("latency", 32'(cyc - e.acc), 32'(SETTLE));
            end
        end
        prev_rv = res_valid;
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_sample(input logic [3:0] d, input int exp_idx, input int gap, output int acc);
        int n;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                check("ch_sel_idle", 32'(ch_sel), 32'(exp_idx));
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("s_ready_timeout", 32'd0, 32'd1);
        check("ch_sel", 32'(ch_sel), 32'(exp_idx));
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic run_frame(input logic [23:0] vec, input logic [1:0] cls, input bit gapped);
        int acc;
        mlp_out = cls;
        for (int i = 0; i < 6; i++) begin
            send_sample(vec[i*4 +: 4], i, gapped ? int'($urandom_range(3, 0)) : 0, acc);
        end
        s_valid = 1'b0;
        sb.push_back('{inp: vec, cls: cls, acc: acc});
    endtask

    task automatic ack_result(input logic [23:0] vec, input logic [1:0] cls, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
        repeat (hold) begin
            mlp_out = mlp_out + 2'd1;
            s_valid = 1'b1;
            s_data  = 4'hA;
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_class", 32'(res_class), 32'(cls));
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_mlp_inp", 32'(mlp_inp), 32'(vec));
            check("hold_busy", 32'(busy), 32'd1);
        end
        s_valid   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        exp_frames++;
        @(negedge clk);
        check("post_ack_res_valid", 32'(res_valid), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("post_ack_s_ready", 32'(s_ready), 32'd1);
        check("post_ack_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int acc, n, c0;
        logic [23:0] vec_b;
        rst_n = 1'b0; s_valid = 1'b1; s_data = 4'h5; mlp_out = 2'd0; res_ready = 1'b0;
        s_valid_b = 1'b0; s_data_b = 4'h0; mlp_out_b = 2'd0; res_ready_b = 1'b1;

        // Reset values with s_valid asserted
        repeat (3) begin
            @(negedge clk);
            check("rst_s_ready", 32'(s_ready), 32'd0);
            check("rst_mlp_inp", 32'(mlp_inp), 32'd0);
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_ch_sel", 32'(ch_sel), 32'd0);
            check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // Full continuous frame 3,7,0,15,9,1
        run_frame(24'h19F073, 2'd2, 1'b0);
        @(negedge clk);
        check("frame_mlp_inp", 32'(mlp_inp), 32'h19F073);
        check("settle_s_ready", 32'(s_ready), 32'd0);
        check("settle_busy", 32'(busy), 32'd1);
        check("settle_ch_sel", 32'(ch_sel), 32'd0);
        ack_result(24'h19F073, 2'd2, 0);

        // Backpressure: 10 held cycles with toggling mlp_out and s_valid high
        @(posedge clk);
        #1;
        run_frame(24'h654321, 2'd1, 1'b0);
        ack_result(24'h654321, 2'd1, 10);

        // Gapped input
        @(posedge clk);
        #1;
        run_frame(24'h5C1248, 2'd3, 1'b1);
        ack_result(24'h5C1248, 2'd3, 2);

        // Mid-frame asynchronous reset after 3 accepts
        @(posedge clk);
        #1;
        send_sample(4'hA, 0, 0, acc);
        send_sample(4'hB, 1, 0, acc);
        send_sample(4'hC, 2, 0, acc);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_frames = 0;
        #1;
        check("async_rst_mlp_inp", 32'(mlp_inp), 32'd0);
        check("async_rst_ch_sel", 32'(ch_sel), 32'd0);
        check("async_rst_s_ready", 32'(s_ready), 32'd0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(24'hABCDEF, 2'd0, 1'b0);
        ack_result(24'hABCDEF, 2'd0, 0);

        // SETTLE_CYCLES=1 instance: latency 1, then 256 back-to-back frames wrap the counter
        @(posedge clk);
        #1;
        c0 = cyc;
        s_valid_b = 1'b1;
        for (int f = 0; f < 256; f++) begin
            mlp_out_b = 2'(f);
            for (int i = 0; i < 6; i++) begin
                s_data_b = 4'(f + i);
                vec_b[i*4 +: 4] = 4'(f + i);
                n = 0;
                @(negedge clk);
                while (!s_ready_b && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!s_ready_b) check("b_s_ready_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #1;
            end
            acc = cyc;
            n = 0;
            @(negedge clk);
            while (!res_valid_b && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (f == 0 || f == 255) begin
                check("b_latency", 32'(cyc - acc), 32'd1);
                check("b_res_class", 32'(res_class_b), 32'(f % 4));
                check("b_mlp_inp", 32'(mlp_inp_b), 32'(vec_b));
            end
            if (f == 1) check("b_frame_cnt_1", 32'(frame_cnt_b), 32'd1);
            @(posedge clk);
            #1;
        end
        s_valid_b = 1'b0;
        check("b_no_stall_cycles", 32'(cyc - c0), 32'd2048);
        @(negedge clk);
        check("b_frame_cnt_wrap", 32'(frame_cnt_b), 32'd0);
        check("b_res_valid_done", 32'(res_valid_b), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
